// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory port arbiter: FSM states, access sizes,
// read/write codes, grant identifiers and the alignment check.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHECK   = 3'd1,
    ACCESS  = 3'd2,
    RESP    = 3'd3,
    RECOVER = 3'd4
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic GNT_FETCH = 1'b0;
  localparam logic GNT_DATA  = 1'b1;

  // An access is rejected when its address is not naturally aligned for its
  // size, or when the size code is the reserved one.
  function automatic logic size_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      SZ_RSVD: bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-requester round-robin picker. Purely combinational: a lone requester
// always wins, and on a tie the requester that was not granted last wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic i_f_req,
  input  logic i_d_req,
  input  logic i_last,
  output logic o_valid,
  output logic o_gnt
);

  // Pick the winner from the request pair and the previous grant.
  always_comb begin
    o_valid = i_f_req | i_d_req;
    o_gnt   = GNT_FETCH;
    if (i_f_req && i_d_req) begin
      o_gnt = (i_last == GNT_FETCH) ? GNT_DATA : GNT_FETCH;
    end else if (i_d_req) begin
      o_gnt = GNT_DATA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store. One
// requester is granted at a time; its request is latched, checked for
// alignment, then driven to memory until mfc or a timeout, and a one-cycle
// ack with an error qualifier is returned. All outputs are registered.
// mem_addr/rw/size/wdata are launched one cycle ahead of mem_en so the memory
// sees a full cycle of address setup before the strobe.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mfc
);

  localparam logic [TO_W-1:0] LP_TO_LAST = TO_W'(TIMEOUT - 1);

  state_t r_state;
  state_t w_next;

  logic              w_arb_valid;
  logic              w_arb_gnt;
  logic              r_last;
  logic              r_gnt;

  logic              r_rw;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic              r_mem_en;
  logic              r_mem_rw;
  logic [1:0]        r_mem_size;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic [TO_W-1:0]   r_cnt;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err_lat;

  logic              r_f_ack;
  logic              r_d_ack;
  logic [DATA_W-1:0] r_f_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_err;

  logic              w_take;
  logic              w_bad;
  logic              w_mfc_hit;
  logic              w_to_hit;
  logic              w_done;
  logic              w_resp_f;
  logic              w_resp_d;

  rr_arb2 u_arb (
    .i_f_req (f_req),
    .i_d_req (d_req),
    .i_last  (r_last),
    .o_valid (w_arb_valid),
    .o_gnt   (w_arb_gnt)
  );

  // mfc only counts once the strobe is actually visible to memory; the
  // timeout fires on the TIMEOUT-th strobe cycle unless mfc arrives with it.
  assign w_take    = (r_state == IDLE) && w_arb_valid;
  assign w_bad     = size_misaligned(r_size, r_addr[1:0]);
  assign w_mfc_hit = (r_state == ACCESS) && r_mem_en && mfc;
  assign w_to_hit  = (r_state == ACCESS) && r_mem_en && !mfc && (r_cnt == LP_TO_LAST);
  assign w_done    = w_mfc_hit || w_to_hit;
  assign w_resp_f  = (r_state == RESP) && (r_gnt == GNT_FETCH);
  assign w_resp_d  = (r_state == RESP) && (r_gnt == GNT_DATA);

  // Next-state decode for the access sequence.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_arb_valid) w_next = CHECK;
      CHECK:   w_next = w_bad ? RESP : ACCESS;
      ACCESS:  if (w_done) w_next = RESP;
      RESP:    w_next = RECOVER;
      RECOVER: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register; reset kills any access in flight without an ack.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Grant bookkeeping; last grant starts at DATA so fetch wins the first tie.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_gnt  <= GNT_FETCH;
      r_last <= GNT_DATA;
    end else if (w_take) begin
      r_gnt  <= w_arb_gnt;
      r_last <= w_arb_gnt;
    end
  end

  // Capture the winning request; fetch is always a word read.
  always_ff @(posedge clk) begin
    if (w_take) begin
      if (w_arb_gnt == GNT_FETCH) begin
        r_rw    <= RW_READ;
        r_size  <= SZ_WORD;
        r_addr  <= f_addr;
        r_wdata <= '0;
      end else begin
        r_rw    <= d_rw;
        r_size  <= d_size;
        r_addr  <= d_addr;
        r_wdata <= d_wdata;
      end
    end
  end

  // Memory-side registers: address/control launched from CHECK, strobe
  // raised the following cycle and dropped on the completing edge.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_mem_en    <= 1'b0;
      r_mem_rw    <= 1'b0;
      r_mem_size  <= 2'b00;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cnt       <= '0;
    end else begin
      r_mem_en <= (r_state == ACCESS) && !w_done;
      if ((r_state == CHECK) && !w_bad) begin
        r_mem_rw    <= r_rw;
        r_mem_size  <= r_size;
        r_mem_addr  <= r_addr;
        r_mem_wdata <= r_wdata;
        r_cnt       <= '0;
      end else if ((r_state == ACCESS) && r_mem_en && !w_done) begin
        r_cnt <= r_cnt + TO_W'(1);
      end
    end
  end

  // Completion result: read data only for successful reads, error on
  // rejection or timeout.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_rdata   <= '0;
      r_err_lat <= 1'b0;
    end else if (r_state == CHECK) begin
      r_rdata   <= '0;
      r_err_lat <= w_bad;
    end else if (w_mfc_hit) begin
      r_rdata   <= (r_rw == RW_READ) ? mem_rdata : '0;
      r_err_lat <= 1'b0;
    end else if (w_to_hit) begin
      r_rdata   <= '0;
      r_err_lat <= 1'b1;
    end
  end

  // Requester-side outputs: one-cycle ack to the granted side, data and err
  // valid only alongside that ack.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_f_ack   <= 1'b0;
      r_d_ack   <= 1'b0;
      r_f_rdata <= '0;
      r_d_rdata <= '0;
      r_err     <= 1'b0;
    end else begin
      r_f_ack   <= w_resp_f;
      r_d_ack   <= w_resp_d;
      r_f_rdata <= w_resp_f ? r_rdata : '0;
      r_d_rdata <= w_resp_d ? r_rdata : '0;
      r_err     <= (r_state == RESP) ? r_err_lat : 1'b0;
    end
  end

  assign f_ack     = r_f_ack;
  assign f_rdata   = r_f_rdata;
  assign d_ack     = r_d_ack;
  assign d_rdata   = r_d_rdata;
  assign err       = r_err;
  assign mem_en    = r_mem_en;
  assign mem_rw    = r_mem_rw;
  assign mem_size  = r_mem_size;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a scoreboard of expected acks,
// a behavioural memory responder with programmable mfc delay, and one task
// per scenario.
module tb_mem_port_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;
  localparam int TO_W    = 4;

  logic              clk;
  logic              clr;
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_ack;
  logic [DATA_W-1:0] f_rdata;
  logic              d_req;
  logic              d_rw;
  logic [1:0]        d_size;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              err;
  logic              mem_en;
  logic              mem_rw;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mfc;

  int n_tests;
  int n_fail;
  int resp_delay;
  int rcnt;

  typedef struct packed {
    logic        fetch;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];

  mem_port_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT),
    .TO_W   (TO_W)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .f_req    (f_req),
    .f_addr   (f_addr),
    .f_ack    (f_ack),
    .f_rdata  (f_rdata),
    .d_req    (d_req),
    .d_rw     (d_rw),
    .d_size   (d_size),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ack    (d_ack),
    .d_rdata  (d_rdata),
    .err      (err),
    .mem_en   (mem_en),
    .mem_rw   (mem_rw),
    .mem_size (mem_size),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mfc      (mfc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hE3A0_1005;
    return {~a[15:0], a[15:0]};
  endfunction

  // Memory responder: raises mfc once mem_en has been high resp_delay cycles
  // (resp_delay == 0 means never respond).
  initial begin
    mfc       = 1'b0;
    mem_rdata = '0;
    rcnt      = 0;
    forever begin
      @(negedge clk);
      if (mem_en) rcnt++;
      else rcnt = 0;
      mfc       = (resp_delay > 0) && mem_en && (rcnt >= resp_delay);
      mem_rdata = mem_model(mem_addr);
    end
  end

  // Scoreboard: every ack pops one expectation.
  initial begin
    exp_t        e;
    logic [31:0] got;
    forever begin
      @(negedge clk);
      if (f_ack || d_ack) begin
        n_tests++;
        if (f_ack && d_ack) begin
          n_fail++;
          $display("FAIL both_acks: f_ack=%0b d_ack=%0b required one-hot", f_ack, d_ack);
        end
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_ack: f_ack=%0b d_ack=%0b with no pending expectation", f_ack, d_ack);
        end else begin
          e   = sb.pop_front();
          got = f_ack ? f_rdata : d_rdata;
          n_tests++;
          if (f_ack !== e.fetch) begin
            n_fail++;
            $display("FAIL ack_side: got fetch=%0b required fetch=%0b", f_ack, e.fetch);
          end
          n_tests++;
          if (got !== e.rdata) begin
            n_fail++;
            $display("FAIL ack_rdata: got %h required %h", got, e.rdata);
          end
          n_tests++;
          if (err !== e.err) begin
            n_fail++;
            $display("FAIL ack_err: got %0b required %0b", err, e.err);
          end
        end
      end
    end
  end

  // Issue one request from a quiet port and report its timing as seen at
  // negedges after the drive point (negedge i follows i rising edges).
  task automatic run_req(input logic fetch, input logic rw, input logic [1:0] sz,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err,
                         output int en_first, output int en_cnt, output int ack_at,
                         output logic [31:0] c_addr, output logic c_rw,
                         output logic [1:0] c_sz, output logic [31:0] c_wd);
    exp_t e;
    repeat (2) @(negedge clk);
    e.fetch = fetch;
    e.rdata = exp_rd;
    e.err   = exp_err;
    sb.push_back(e);
    en_first = 0;
    en_cnt   = 0;
    ack_at   = 0;
    c_addr   = '0;
    c_rw     = 1'b0;
    c_sz     = 2'b00;
    c_wd     = '0;
    if (fetch) begin
      f_req  = 1'b1;
      f_addr = addr;
    end else begin
      d_req   = 1'b1;
      d_rw    = rw;
      d_size  = sz;
      d_addr  = addr;
      d_wdata = wd;
    end
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (mem_en) begin
        if (en_cnt == 0) begin
          en_first = i;
          c_addr   = mem_addr;
          c_rw     = mem_rw;
          c_sz     = mem_size;
          c_wd     = mem_wdata;
        end
        en_cnt++;
      end
      if (fetch ? f_ack : d_ack) begin
        ack_at = i;
        if (fetch) f_req = 1'b0;
        else d_req = 1'b0;
        break;
      end
    end
    n_tests++;
    if (ack_at == 0) begin
      n_fail++;
      $display("FAIL ack_timeout: no ack within 100 cycles for addr %h", addr);
      f_req = 1'b0;
      d_req = 1'b0;
    end
  endtask

  task automatic test_reset();
    clr   = 1'b0;
    f_req = 1'b0;
    d_req = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({mem_en, mem_rw, mem_size, f_ack, d_ack, err} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 0000000",
               {mem_en, mem_rw, mem_size, f_ack, d_ack, err});
    end
    n_tests++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_mem_bus: addr=%h wdata=%h required 0", mem_addr, mem_wdata);
    end
    n_tests++;
    if (f_rdata !== '0 || d_rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_rdata: f=%h d=%h required 0", f_rdata, d_rdata);
    end
  endtask

  task automatic test_tie();
    exp_t        e;
    logic [31:0] exp_addr [3];
    int          nburst, nack, low_run;
    logic        prev_en;
    exp_addr[0] = 32'h400;
    exp_addr[1] = 32'h800;
    exp_addr[2] = 32'h400;
    clr        = 1'b0;
    resp_delay = 2;
    f_req  = 1'b1;
    f_addr = 32'h400;
    d_req  = 1'b1;
    d_rw   = 1'b1;
    d_size = 2'b10;
    d_addr = 32'h800;
    d_wdata = '0;
    for (int k = 0; k < 3; k++) begin
      e.fetch = (k != 1);
      e.rdata = mem_model(exp_addr[k]);
      e.err   = 1'b0;
      sb.push_back(e);
    end
    @(negedge clk);
    clr     = 1'b1;
    nburst  = 0;
    nack    = 0;
    low_run = 0;
    prev_en = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mem_en && !prev_en) begin
        if (nburst > 0) begin
          n_tests++;
          if (low_run < 2) begin
            n_fail++;
            $display("FAIL tie_gap: burst %0d gap %0d cycles required >= 2", nburst, low_run);
          end
        end
        if (nburst < 3) begin
          n_tests++;
          if (mem_addr !== exp_addr[nburst]) begin
            n_fail++;
            $display("FAIL tie_order: burst %0d addr %h required %h", nburst, mem_addr, exp_addr[nburst]);
          end
        end
        nburst++;
      end
      if (mem_en) low_run = 0;
      else low_run++;
      prev_en = mem_en;
      if (f_ack || d_ack) nack++;
      if (nack == 3) begin
        f_req = 1'b0;
        d_req = 1'b0;
        break;
      end
    end
    n_tests++;
    if (nack != 3) begin
      n_fail++;
      $display("FAIL tie_acks: got %0d acks required 3", nack);
      f_req = 1'b0;
      d_req = 1'b0;
    end
  endtask

  task automatic test_fetch_alone();
    int en_first, en_cnt, ack_at;
    logic [31:0] c_addr, c_wd;
    logic c_rw;
    logic [1:0] c_sz;
    resp_delay = 3;
    run_req(1'b1, 1'b1, 2'b10, 32'h100, 32'h0, 32'hE3A0_1005, 1'b0,
            en_first, en_cnt, ack_at, c_addr, c_rw, c_sz, c_wd);
    n_tests++;
    if (en_first != 3 || en_cnt != 3) begin
      n_fail++;
      $display("FAIL fetch_strobe: first=%0d len=%0d required first=3 len=3", en_first, en_cnt);
    end
    n_tests++;
    if (ack_at != 7) begin
      n_fail++;
      $display("FAIL fetch_latency: ack at %0d required 7", ack_at);
    end
    n_tests++;
    if (c_rw !== 1'b1 || c_sz !== 2'b10 || c_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL fetch_bus: rw=%0b size=%b addr=%h required rw=1 size=10 addr=00000100",
               c_rw, c_sz, c_addr);
    end
  endtask

  task automatic test_data_access();
    int en_first, en_cnt, ack_at;
    logic [31:0] c_addr, c_wd;
    logic c_rw;
    logic [1:0] c_sz;
    resp_delay = 2;
    run_req(1'b0, 1'b0, 2'b00, 32'h203, 32'hAB, 32'h0, 1'b0,
            en_first, en_cnt, ack_at, c_addr, c_rw, c_sz, c_wd);
    n_tests++;
    if (c_rw !== 1'b0 || c_sz !== 2'b00 || c_addr !== 32'h203 || c_wd !== 32'hAB) begin
      n_fail++;
      $display("FAIL write_bus: rw=%0b size=%b addr=%h wdata=%h required 0/00/00000203/000000ab",
               c_rw, c_sz, c_addr, c_wd);
    end
    n_tests++;
    if (ack_at != 6) begin
      n_fail++;
      $display("FAIL write_latency: ack at %0d required 6", ack_at);
    end
    resp_delay = 1;
    run_req(1'b0, 1'b1, 2'b01, 32'h202, 32'h0, mem_model(32'h202), 1'b0,
            en_first, en_cnt, ack_at, c_addr, c_rw, c_sz, c_wd);
    n_tests++;
    if (c_rw !== 1'b1 || c_sz !== 2'b01 || en_cnt != 1) begin
      n_fail++;
      $display("FAIL half_read: rw=%0b size=%b len=%0d required 1/01/1", c_rw, c_sz, en_cnt);
    end
  endtask

  task automatic test_misaligned();
    logic [1:0]  sz_tab [3];
    logic [31:0] ad_tab [3];
    int en_first, en_cnt, ack_at;
    logic [31:0] c_addr, c_wd;
    logic c_rw;
    logic [1:0] c_sz;
    sz_tab[0] = 2'b10; ad_tab[0] = 32'h202;
    sz_tab[1] = 2'b01; ad_tab[1] = 32'h201;
    sz_tab[2] = 2'b11; ad_tab[2] = 32'h200;
    resp_delay = 1;
    for (int k = 0; k < 3; k++) begin
      run_req(1'b0, 1'b1, sz_tab[k], ad_tab[k], 32'h0, 32'h0, 1'b1,
              en_first, en_cnt, ack_at, c_addr, c_rw, c_sz, c_wd);
      n_tests++;
      if (en_cnt != 0 || ack_at != 3) begin
        n_fail++;
        $display("FAIL misaligned_%0d: strobe len %0d ack at %0d required 0 and 3",
                 k, en_cnt, ack_at);
      end
    end
  endtask

  task automatic test_timeout();
    int en_first, en_cnt, ack_at;
    logic [31:0] c_addr, c_wd;
    logic c_rw;
    logic [1:0] c_sz;
    resp_delay = 0;
    run_req(1'b1, 1'b1, 2'b10, 32'h500, 32'h0, 32'h0, 1'b1,
            en_first, en_cnt, ack_at, c_addr, c_rw, c_sz, c_wd);
    n_tests++;
    if (en_cnt != TIMEOUT || ack_at != TIMEOUT + 4) begin
      n_fail++;
      $display("FAIL timeout_abort: strobe len %0d ack at %0d required %0d and %0d",
               en_cnt, ack_at, TIMEOUT, TIMEOUT + 4);
    end
    resp_delay = TIMEOUT;
    run_req(1'b1, 1'b1, 2'b10, 32'h504, 32'h0, mem_model(32'h504), 1'b0,
            en_first, en_cnt, ack_at, c_addr, c_rw, c_sz, c_wd);
    n_tests++;
    if (en_cnt != TIMEOUT || ack_at != TIMEOUT + 4) begin
      n_fail++;
      $display("FAIL timeout_mfc_wins: strobe len %0d ack at %0d required %0d and %0d",
               en_cnt, ack_at, TIMEOUT, TIMEOUT + 4);
    end
  endtask

  task automatic test_reset_mid_access();
    exp_t e;
    logic seen, f_done, d_done, first_seen;
    repeat (2) @(negedge clk);
    resp_delay = 0;
    f_req  = 1'b1;
    f_addr = 32'h104;
    d_req  = 1'b1;
    d_rw   = 1'b1;
    d_size = 2'b10;
    d_addr = 32'h300;
    seen   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_en) begin
        seen = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!seen || mem_addr !== 32'h300) begin
      n_fail++;
      $display("FAIL pre_reset_grant: seen=%0b addr=%h required 1 and 00000300", seen, mem_addr);
    end
    @(negedge clk);
    clr = 1'b0;
    #1;
    n_tests++;
    if (mem_en !== 1'b0 || f_ack !== 1'b0 || d_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_kill: mem_en=%0b f_ack=%0b d_ack=%0b required 000", mem_en, f_ack, d_ack);
    end
    @(negedge clk);
    resp_delay = 2;
    e.fetch = 1'b1; e.rdata = mem_model(32'h104); e.err = 1'b0;
    sb.push_back(e);
    e.fetch = 1'b0; e.rdata = mem_model(32'h300); e.err = 1'b0;
    sb.push_back(e);
    clr        = 1'b1;
    f_done     = 1'b0;
    d_done     = 1'b0;
    first_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_en && !first_seen) begin
        first_seen = 1'b1;
        n_tests++;
        if (mem_addr !== 32'h104) begin
          n_fail++;
          $display("FAIL post_reset_priority: addr %h required 00000104", mem_addr);
        end
      end
      if (f_ack) begin
        f_req  = 1'b0;
        f_done = 1'b1;
      end
      if (d_ack) begin
        d_req  = 1'b0;
        d_done = 1'b1;
      end
      if (f_done && d_done) break;
    end
    n_tests++;
    if (!(f_done && d_done)) begin
      n_fail++;
      $display("FAIL post_reset_acks: fetch=%0b data=%0b required both", f_done, d_done);
      f_req = 1'b0;
      d_req = 1'b0;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    resp_delay = 0;
    clr        = 1'b0;
    f_req      = 1'b0;
    f_addr     = '0;
    d_req      = 1'b0;
    d_rw       = 1'b1;
    d_size     = 2'b10;
    d_addr     = '0;
    d_wdata    = '0;
    test_reset();
    test_tie();
    test_fetch_alone();
    test_data_access();
    test_misaligned();
    test_timeout();
    test_reset_mid_access();
    repeat (4) @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expectations left required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
